deskew_writeback_ctrl: RTL

// Parametrised output de-skew and writeback sequencer between the VPU and the output buffer.

---
 rtl/deskew_writeback_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/deskew_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// deskew_writeback_ctrl
//
// Sits between the VPU and the output buffer. Lane j of a result row arrives
// j cycles after lane 0. A per-lane delay line realigns the lanes into one
// packed row. Complete rows are then written to consecutive buffer addresses
// until the programmed row count is reached, and done pulses for one cycle.
// Rows whose enabled lanes disagree on valid are flagged, not written. Rows
// that arrive while no job is running are also flagged, not written.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start         1-cycle pulse; latches base_addr, row_count and col_mask
//   base_addr     first write address of the job
//   row_count     number of rows to write (0 completes immediately)
//   col_mask      1 = lane enabled
//   in_data       skewed lane data; lane j is in_data[j*DATA_W +: DATA_W]
//   in_valid      per-lane valid, skewed like in_data
//   wr_en         output-buffer write strobe
//   wr_addr       write address (wraps modulo 2^ADDR_W)
//   wr_data       aligned row; disabled lanes are forced to 0
//   busy          high while the job is running
//   done          1-cycle pulse at the end of a job
//   rows_written  rows written in the current or last job
//   err_misalign  sticky: enabled lanes disagreed on valid during a job
//   err_stray     sticky: an aligned row arrived while no job was running
// -----------------------------------------------------------------------------
module deskew_writeback_ctrl #(
    parameter int LANES  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W:0]           row_count,
    input  logic [LANES-1:0]          col_mask,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES-1:0]          in_valid,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           rows_written,
    output logic                      err_misalign,
    output logic                      err_stray
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W:0]         count_q;
    logic [LANES-1:0]        mask_q;

    logic                    wr_en_q;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic [LANES*DATA_W-1:0] wr_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ADDR_W:0]         rows_written_q;
    logic                    err_misalign_q;
    logic                    err_stray_q;

    logic [LANES*DATA_W-1:0] aligned_data;
    logic [LANES-1:0]        aligned_valid;
    logic [LANES*DATA_W-1:0] row_masked_d;
    logic                    row_full_d;
    logic                    row_seen_d;
    logic [ADDR_W:0]         rows_next_d;

    // Lane j is delayed by LANES-1-j cycles, so every lane of a row lines up
    // in the same cycle as the last lane, which has no delay. The delay lines
    // run in every state. The FSM only decides what to do with each aligned row.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int DEPTH = LANES - 1 - j;

        if (DEPTH == 0) begin : g_bypass
            assign aligned_data[j*DATA_W +: DATA_W] = in_data[j*DATA_W +: DATA_W];
            assign aligned_valid[j]                 = in_valid[j];
        end else begin : g_pipe
            logic [DATA_W-1:0] data_q  [DEPTH];
            logic              valid_q [DEPTH];

            always_ff @(posedge clk) begin
                // NOTE: the delay stages are cleared on reset, like any other
                // state. Otherwise a half-delivered row from before the reset
                // could complete afterwards and be taken as a real row.
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        data_q[k]  <= '0;
                        valid_q[k] <= 1'b0;
                    end
                end else begin
                    data_q[0]  <= in_data[j*DATA_W +: DATA_W];
                    valid_q[0] <= in_valid[j];
                    for (int k = 1; k < DEPTH; k++) begin
                        data_q[k]  <= data_q[k-1];
                        valid_q[k] <= valid_q[k-1];
                    end
                end
            end

            assign aligned_data[j*DATA_W +: DATA_W] = data_q[DEPTH-1];
            assign aligned_valid[j]                 = valid_q[DEPTH-1];
        end
    end

    // Classify the aligned row. Only lanes enabled in the latched mask count.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned.
        row_masked_d = '0;
        for (int j = 0; j < LANES; j++) begin
            if (mask_q[j]) begin
                row_masked_d[j*DATA_W +: DATA_W] = aligned_data[j*DATA_W +: DATA_W];
            end
        end
        // With an empty mask no row can ever be full.
        row_full_d  = (mask_q != '0) && ((aligned_valid & mask_q) == mask_q);
        row_seen_d  = |(aligned_valid & mask_q);
        rows_next_d = rows_written_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            count_q        <= '0;
            mask_q         <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rows_written_q <= '0;
            err_misalign_q <= 1'b0;
            err_stray_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here updates
            // from the values it held before this clock edge.
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        count_q        <= row_count;
                        mask_q         <= col_mask;
                        rows_written_q <= '0;
                        err_misalign_q <= 1'b0;
                        err_stray_q    <= 1'b0;
                        if (row_count == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else if (row_seen_d) begin
                        err_stray_q <= 1'b1;
                    end
                end

                S_RUN: begin
                    // A start pulse here is ignored. The job keeps its config.
                    if (row_full_d) begin
                        wr_en_q        <= 1'b1;
                        wr_addr_q      <= base_q + rows_written_q[ADDR_W-1:0];
                        wr_data_q      <= row_masked_d;
                        rows_written_q <= rows_next_d;
                        if (rows_next_d == count_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                        end
                    end else if (row_seen_d) begin
                        err_misalign_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                    if (row_seen_d) begin
                        err_stray_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rows_written = rows_written_q;
    assign err_misalign = err_misalign_q;
    assign err_stray    = err_stray_q;

endmodule
